// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register bank's single write port.
// One registered grant per cycle; drives the write bus, per-register enables and a commit counter.
module regfile_wr_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 5,
   parameter int DW   = 32,
   parameter int NREG = 32
) (
   input  logic               clk,
   input  logic               clr_n,
   input  logic               stall,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    grant,
   output logic               wr_en,
   output logic [AW-1:0]      wr_addr,
   output logic [DW-1:0]      wr_data,
   output logic [NREG-1:0]    reg_en,
   output logic [15:0]        wr_count
);

   localparam int unsigned NREQ_U = NREQ;
   localparam int unsigned PW     = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   rr_next;
   logic [PW-1:0]   win_idx;
   logic [NREQ-1:0] win_oh;
   logic            win_valid;
   int unsigned     scan_idx;

   // Scan from rr_ptr upward with wrap; the first pending request wins.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      win_oh    = '0;
      scan_idx  = 0;
      for (int unsigned k = 0; k < NREQ_U; k++) begin
         scan_idx = (32'(rr_ptr) + k) % NREQ_U;
         if (!win_valid && !stall && req[scan_idx]) begin
            win_valid = 1'b1;
            win_idx   = PW'(scan_idx);
         end
      end
      if (win_valid) begin
         win_oh[win_idx] = 1'b1;
      end
      rr_next = PW'((32'(win_idx) + 1) % NREQ_U);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         grant    <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         wr_count <= '0;
         rr_ptr   <= '0;
      end else begin
         grant <= win_oh;
         wr_en <= win_valid;
         if (win_valid) begin
            wr_addr  <= req_addr[int'(win_idx)*AW +: AW];
            wr_data  <= req_data[int'(win_idx)*DW +: DW];
            wr_count <= wr_count + 16'd1;
            rr_ptr   <= rr_next;
         end
      end
   end

   // Register 0 is hardwired zero, so its enable is never raised.
   always_comb begin
      reg_en = '0;
      if (wr_en && (wr_addr != '0)) begin
         reg_en[wr_addr] = 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Table-driven bench for regfile_wr_arbiter with an expectation queue,
// plus hand sequences for mid-transfer reset and counter wrap.
module tb_regfile_wr_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int NREG = 32;
   localparam int NVEC = 22;

   logic               clk = 1'b0;
   logic               clr_n = 1'b0;
   logic               stall = 1'b0;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ*AW-1:0] req_addr = '0;
   logic [NREQ*DW-1:0] req_data = '0;
   logic [NREQ-1:0]    grant;
   logic               wr_en;
   logic [AW-1:0]      wr_addr;
   logic [DW-1:0]      wr_data;
   logic [NREG-1:0]    reg_en;
   logic [15:0]        wr_count;

   regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREG(NREG)) dut (
      .clk(clk), .clr_n(clr_n), .stall(stall), .req(req),
      .req_addr(req_addr), .req_data(req_data), .grant(grant),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .reg_en(reg_en), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic               stall;
      logic [NREQ-1:0]    req;
      logic [NREQ-1:0]    exp_grant;
      logic [NREQ*AW-1:0] addr;
      logic [NREQ*DW-1:0] data;
   } vec_t;

   typedef struct {
      logic [NREQ-1:0] grant;
      logic            wr_en;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   data;
   } exp_t;

   vec_t        vecs[NVEC];
   exp_t        sb[$];
   logic [15:0] exp_count;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int v, input logic s, input logic [3:0] r, input logic [3:0] g);
      vec_t t;
      t.stall = s;
      t.req = r;
      t.exp_grant = g;
      for (int i = 0; i < NREQ; i++) begin
         t.addr[i*AW +: AW] = 5'(8*i + (v % 7) + 1);
         t.data[i*DW +: DW] = {8'(v), 8'(i), 16'h5A3C};
      end
      return t;
   endfunction

   function automatic exp_t expect_of(input vec_t t);
      exp_t e;
      e.grant = t.exp_grant;
      e.wr_en = (t.exp_grant != '0);
      e.addr = '0;
      e.data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (t.exp_grant[i]) begin
            e.addr = t.addr[i*AW +: AW];
            e.data = t.data[i*DW +: DW];
         end
      end
      return e;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, ".grant"}, 32'(grant), 32'h0);
      check({tag, ".wr_en"}, 32'(wr_en), 32'h0);
      check({tag, ".wr_addr"}, 32'(wr_addr), 32'h0);
      check({tag, ".wr_data"}, wr_data, 32'h0);
      check({tag, ".reg_en"}, reg_en, 32'h0);
      check({tag, ".wr_count"}, 32'(wr_count), 32'h0);
   endtask

   initial begin
      exp_t  e;
      vec_t  t;
      string tag;
      logic [31:0] exp_reg_en;

      // Fairness sequence with handshake drops, then single write, zero register, stall, rr wrap.
      vecs[0]  = mk(0,  1'b0, 4'b1111, 4'b0001);
      vecs[1]  = mk(1,  1'b0, 4'b1110, 4'b0010);
      vecs[2]  = mk(2,  1'b0, 4'b1101, 4'b0100);
      vecs[3]  = mk(3,  1'b0, 4'b1011, 4'b1000);
      vecs[4]  = mk(4,  1'b0, 4'b0111, 4'b0001);
      vecs[5]  = mk(5,  1'b0, 4'b0000, 4'b0000);
      vecs[6]  = mk(6,  1'b0, 4'b0100, 4'b0100);
      vecs[7]  = mk(7,  1'b0, 4'b0000, 4'b0000);
      vecs[8]  = mk(8,  1'b0, 4'b0001, 4'b0001);
      vecs[9]  = mk(9,  1'b0, 4'b0000, 4'b0000);
      vecs[10] = mk(10, 1'b0, 4'b1000, 4'b1000);
      vecs[11] = mk(11, 1'b0, 4'b0000, 4'b0000);
      vecs[12] = mk(12, 1'b1, 4'b0011, 4'b0000);
      vecs[13] = mk(13, 1'b1, 4'b0011, 4'b0000);
      vecs[14] = mk(14, 1'b1, 4'b0011, 4'b0000);
      vecs[15] = mk(15, 1'b0, 4'b0011, 4'b0001);
      vecs[16] = mk(16, 1'b1, 4'b0010, 4'b0000);
      vecs[17] = mk(17, 1'b0, 4'b0010, 4'b0010);
      vecs[18] = mk(18, 1'b0, 4'b0100, 4'b0100);
      vecs[19] = mk(19, 1'b0, 4'b1001, 4'b1000);
      vecs[20] = mk(20, 1'b0, 4'b0001, 4'b0001);
      vecs[21] = mk(21, 1'b0, 4'b0000, 4'b0000);
      vecs[6].addr[2*AW +: AW] = 5'd5;
      vecs[6].data[2*DW +: DW] = 32'hDEADBEEF;
      vecs[8].addr[0 +: AW] = 5'd0;

      // Reset state, then a grant left in flight when reset is reasserted.
      #3;
      check_all_zero("reset");
      #9 clr_n = 1'b1;
      @(posedge clk); #1;
      req = 4'b1111;
      req_addr = {5'd4, 5'd3, 5'd2, 5'd1};
      req_data = {32'h4, 32'h3, 32'h2, 32'h1};
      @(posedge clk); #1;
      check("pre_reset.grant", 32'(grant), 32'h1);
      check("pre_reset.wr_en", 32'(wr_en), 32'h1);
      check("pre_reset.reg_en", reg_en, 32'h2);
      check("pre_reset.wr_count", 32'(wr_count), 32'h1);
      #2 clr_n = 1'b0;
      #1 check_all_zero("mid_reset");
      @(posedge clk); #1;
      check_all_zero("held_reset");
      #1 clr_n = 1'b1;

      exp_count = 16'h0;
      for (int v = 0; v < NVEC; v++) begin
         t = vecs[v];
         stall = t.stall;
         req = t.req;
         req_addr = t.addr;
         req_data = t.data;
         sb.push_back(expect_of(t));
         @(posedge clk); #1;
         e = sb.pop_front();
         if (e.wr_en) exp_count = exp_count + 16'd1;
         tag = $sformatf("vec%0d", v);
         exp_reg_en = (e.wr_en && e.addr != '0) ? (32'h1 << e.addr) : 32'h0;
         check({tag, ".grant"}, 32'(grant), 32'(e.grant));
         check({tag, ".wr_en"}, 32'(wr_en), 32'(e.wr_en));
         if (e.wr_en) begin
            check({tag, ".wr_addr"}, 32'(wr_addr), 32'(e.addr));
            check({tag, ".wr_data"}, wr_data, e.data);
         end
         check({tag, ".reg_en"}, reg_en, exp_reg_en);
         check({tag, ".wr_count"}, 32'(wr_count), 32'(exp_count));
      end
      check("vec6.reg_en_addr5_literal", 32'(vecs[6].addr[2*AW +: AW]), 32'd5);

      // Counter wrap: a single requester holding req wins every cycle.
      stall = 1'b0;
      req = 4'b0001;
      req_addr = {5'd4, 5'd3, 5'd2, 5'd9};
      req_data = {32'h4, 32'h3, 32'h2, 32'h99};
      while (exp_count != 16'hFFFF) begin
         @(posedge clk); #1;
         exp_count = exp_count + 16'd1;
      end
      check("wrap.pre_count", 32'(wr_count), 32'h0000FFFF);
      check("wrap.pre_grant", 32'(grant), 32'h1);
      @(posedge clk); #1;
      check("wrap.count", 32'(wr_count), 32'h00000000);
      check("wrap.wr_en", 32'(wr_en), 32'h1);
      check("wrap.reg_en", reg_en, 32'h200);
      req = 4'b0000;
      @(posedge clk); #1;
      check("idle.wr_en", 32'(wr_en), 32'h0);
      check("idle.wr_count", 32'(wr_count), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
